// File: rtl/pcm_voice_mixer.sv
// pcm_voice_mixer
//   Multi-voice PCM sample player. Up to VOICES independent regions of one shared
//   single-port sample ROM are fetched round-robin on every sample tick. The fetched
//   samples are summed with saturation into one signed output stream.
//
//   Optional feature macro: PCM_VOICE_VOL_EN
//     Adds a 4-bit volume per voice (gain = (vol+1)/16). Without it, every voice
//     plays at unity gain and the vol port does not exist.
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high reset
//   trig        per-voice start pulse (one clock)
//   stop        per-voice stop pulse (one clock)
//   start_addr  per-voice start address, voice v at [v*ADDR_W +: ADDR_W]
//   length      per-voice sample count, same packing as start_addr
//   loop        per-voice loop enable
//   vol         per-voice volume, 4 bits each (PCM_VOICE_VOL_EN only)
//   rom_a       sample ROM address
//   rom_rd      ROM read strobe; rom_d is valid one clock later
//   rom_d       ROM read data (unsigned, offset-binary)
//   audio_out   signed mixed sample, held between strobes
//   audio_stb   one-clock pulse when audio_out updates
//   busy        per-voice playing flag
module pcm_voice_mixer #(
  parameter int VOICES = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int OUT_W  = 16,
  parameter int DIV    = 2177
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [VOICES-1:0]          trig,
  input  logic [VOICES-1:0]          stop,
  input  logic [VOICES*ADDR_W-1:0]   start_addr,
  input  logic [VOICES*ADDR_W-1:0]   length,
  input  logic [VOICES-1:0]          loop,
`ifdef PCM_VOICE_VOL_EN
  input  logic [VOICES*4-1:0]        vol,
`endif
  output logic [ADDR_W-1:0]          rom_a,
  output logic                       rom_rd,
  input  logic [DATA_W-1:0]          rom_d,
  output logic [OUT_W-1:0]           audio_out,
  output logic                       audio_stb,
  output logic [VOICES-1:0]          busy
);

  localparam int CNT_W  = $clog2(DIV + 1);
  localparam int VIDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam int SUM_W  = OUT_W + 3;
  localparam int SHIFT  = OUT_W - DATA_W;

  localparam logic [CNT_W-1:0]        DIV_C  = CNT_W'(DIV);
  localparam logic [VIDX_W-1:0]       LAST_V = VIDX_W'(VOICES - 1);
  localparam logic [DATA_W-1:0]       MID    = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPT, S_MIX} state_t;

  state_t              state_reg, state_next;
  logic [VIDX_W-1:0]   vidx_reg, vidx_next;
  logic [CNT_W-1:0]    count_reg;
  logic                tick_reg;

  logic [ADDR_W-1:0]        addr_v [VOICES];
  logic signed [SUM_W-1:0]  term_v [VOICES];
  logic signed [SUM_W-1:0]  sum;
  logic [OUT_W-1:0]         mix_sat;

  // Free-running prescaler. The tick is registered so the sweep starts one
  // clock after the wrap, which gives 2*VOICES+2 clocks from tick to output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
      tick_reg  <= 1'b0;
    end else begin
      tick_reg  <= (count_reg == DIV_C);
      count_reg <= (count_reg == DIV_C) ? '0 : count_reg + 1'b1;
    end
  end

  // Sequencer state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      vidx_reg  <= '0;
    end else begin
      state_reg <= state_next;
      vidx_reg  <= vidx_next;
    end
  end

  // Sequencer next state and ROM port. The ROM is only driven in ISSUE, so at
  // most one read is ever outstanding.
  always_comb begin
    state_next = state_reg;
    vidx_next  = vidx_reg;
    rom_rd     = 1'b0;
    rom_a      = '0;
    case (state_reg)
      S_IDLE: begin
        if (tick_reg) begin
          state_next = S_ISSUE;
          vidx_next  = '0;
        end
      end
      S_ISSUE: begin
        if (busy[vidx_reg]) begin
          rom_rd = 1'b1;
          rom_a  = addr_v[vidx_reg];
        end
        state_next = S_CAPT;
      end
      S_CAPT: begin
        if (vidx_reg == LAST_V) begin
          state_next = S_MIX;
        end else begin
          state_next = S_ISSUE;
          vidx_next  = vidx_reg + 1'b1;
        end
      end
      S_MIX: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < VOICES; gi++) begin : g_voice
      logic [ADDR_W-1:0]        start_reg, len_reg, offset_reg;
      logic                     loop_reg, busy_reg, fetched_reg;
      logic [DATA_W-1:0]        sample_reg;
      logic [ADDR_W-1:0]        len_in;
      logic                     trig_ok, issue_here, capt_here;
      logic signed [DATA_W-1:0] s_signed;
      logic signed [SUM_W-1:0]  s_ext;

      assign len_in     = length[gi*ADDR_W +: ADDR_W];
      assign trig_ok    = trig[gi] && (len_in != '0);
      assign issue_here = (state_reg == S_ISSUE) && (vidx_reg == VIDX_W'(gi));
      assign capt_here  = (state_reg == S_CAPT)  && (vidx_reg == VIDX_W'(gi));

      // fetched_reg remembers that ISSUE found the voice busy, so CAPT only
      // captures data that was actually read for this voice. A stop or a
      // retrigger cancels an outstanding capture.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          start_reg   <= '0;
          len_reg     <= '0;
          offset_reg  <= '0;
          loop_reg    <= 1'b0;
          busy_reg    <= 1'b0;
          fetched_reg <= 1'b0;
          sample_reg  <= MID;
        end else begin
          if (issue_here) begin
            fetched_reg <= busy_reg;
            if (!busy_reg) begin
              sample_reg <= MID;
            end
          end
          if (capt_here && fetched_reg) begin
            sample_reg  <= rom_d;
            fetched_reg <= 1'b0;
            if (offset_reg == len_reg - 1'b1) begin
              if (loop_reg) begin
                offset_reg <= '0;
              end else begin
                busy_reg <= 1'b0;
              end
            end else begin
              offset_reg <= offset_reg + 1'b1;
            end
          end
          if (trig_ok) begin
            start_reg   <= start_addr[gi*ADDR_W +: ADDR_W];
            len_reg     <= len_in;
            loop_reg    <= loop[gi];
            offset_reg  <= '0;
            busy_reg    <= 1'b1;
            fetched_reg <= 1'b0;
            if (issue_here) begin
              sample_reg <= MID;
            end
          end else if (stop[gi] && !trig[gi]) begin
            busy_reg    <= 1'b0;
            fetched_reg <= 1'b0;
            sample_reg  <= MID;
          end
        end
      end

      assign busy[gi]   = busy_reg;
      assign addr_v[gi] = start_reg + offset_reg;

      // Offset-binary to two's complement: flip the MSB
      assign s_signed = {~sample_reg[DATA_W-1], sample_reg[DATA_W-2:0]};
      assign s_ext    = SUM_W'(s_signed);

`ifdef PCM_VOICE_VOL_EN
      logic [4:0]              gain;
      logic signed [SUM_W-1:0] scaled;
      assign gain   = {1'b0, vol[gi*4 +: 4]} + 5'd1;
      assign scaled = (s_ext * $signed({{(SUM_W-5){1'b0}}, gain})) >>> 4;
      assign term_v[gi] = scaled <<< SHIFT;
`else
      assign term_v[gi] = s_ext <<< SHIFT;
`endif
    end
  endgenerate

  // Sum in OUT_W+3 bits (enough headroom for 8 full-scale voices), then clamp.
  always_comb begin
    sum = '0;
    for (int v = 0; v < VOICES; v++) begin
      sum = sum + term_v[v];
    end
    if (sum > SAT_HI) begin
      mix_sat = SAT_HI[OUT_W-1:0];
    end else if (sum < SAT_LO) begin
      mix_sat = SAT_LO[OUT_W-1:0];
    end else begin
      mix_sat = sum[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      audio_out <= '0;
      audio_stb <= 1'b0;
    end else begin
      audio_stb <= (state_reg == S_MIX);
      if (state_reg == S_MIX) begin
        audio_out <= mix_sat;
      end
    end
  end

endmodule

// File: tb/tb_pcm_voice_mixer.sv
// tb_pcm_voice_mixer
//   Directed test of pcm_voice_mixer with VOICES=2, DIV=15 and a behavioural
//   ROM whose contents are selected by rom_mode (0: ROM[i]=i, 1: all 0xFF,
//   2: all 0x00).
module tb_pcm_voice_mixer;
  localparam int VOICES = 2;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int OUT_W  = 16;
  localparam int DIV    = 15;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [VOICES-1:0]        trig, stop, loop;
  logic [VOICES*ADDR_W-1:0] start_addr, length;
  logic [ADDR_W-1:0]        rom_a;
  logic                     rom_rd;
  logic [DATA_W-1:0]        rom_d = '0;
  logic [OUT_W-1:0]         audio_out;
  logic                     audio_stb;
  logic [VOICES-1:0]        busy;
`ifdef PCM_VOICE_VOL_EN
  logic [VOICES*4-1:0]      vol = '1;
`endif

  pcm_voice_mixer #(
    .VOICES(VOICES), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUT_W(OUT_W), .DIV(DIV)
  ) dut (
    .clk(clk),
    .reset(reset),
    .trig(trig),
    .stop(stop),
    .start_addr(start_addr),
    .length(length),
    .loop(loop),
`ifdef PCM_VOICE_VOL_EN
    .vol(vol),
`endif
    .rom_a(rom_a),
    .rom_rd(rom_rd),
    .rom_d(rom_d),
    .audio_out(audio_out),
    .audio_stb(audio_stb),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rom_mode = 0;

  logic [ADDR_W-1:0] addr_q[$];
  logic [OUT_W-1:0]  audio_q[$];
  logic [VOICES-1:0] busy_q[$];

  // One-clock read latency ROM
  always @(posedge clk) begin
    if (rom_rd) begin
      case (rom_mode)
        1:       rom_d <= 8'hFF;
        2:       rom_d <= 8'h00;
        default: rom_d <= rom_a[7:0];
      endcase
    end
  end

  always @(negedge clk) begin
    if (!reset && rom_rd) begin
      addr_q.push_back(rom_a);
      $display("rom read  addr=0x%04h", rom_a);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
    $display("check %-16s observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic set_voice(input int v, input logic [15:0] sa, input logic [15:0] len, input logic lp);
    start_addr[v*ADDR_W +: ADDR_W] = sa;
    length[v*ADDR_W +: ADDR_W]     = len;
    loop[v]                        = lp;
  endtask

  task automatic pulse(input logic [1:0] t, input logic [1:0] s);
    trig = t;
    stop = s;
    @(negedge clk);
    trig = '0;
    stop = '0;
  endtask

  // Returns at the negedge where audio_stb is high, i.e. while the sequencer is idle
  task automatic sync_stb();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!audio_stb && n < 64);
    if (!audio_stb) check("sync_timeout", 32'(audio_stb), 32'd1);
  endtask

  task automatic collect(input int n);
    int got = 0;
    int cyc = 0;
    audio_q.delete();
    busy_q.delete();
    while (got < n && cyc < 32 * n + 32) begin
      @(negedge clk);
      cyc++;
      if (audio_stb) begin
        audio_q.push_back(audio_out);
        busy_q.push_back(busy);
        got++;
        $display("audio strobe out=0x%04h busy=%b", audio_out, busy);
      end
    end
    if (got != n) check("collect_timeout", 32'(got), 32'(n));
  endtask

  initial begin
    int cyc;
    reset = 1'b1;
    trig = '0;
    stop = '0;
    start_addr = '0;
    length = '0;
    loop = '0;
    repeat (3) @(negedge clk);

    check("rst_busy", 32'(busy), 32'd0);
    check("rst_audio", 32'(audio_out), 32'd0);
    check("rst_stb", 32'(audio_stb), 32'd0);
    check("rst_rom_rd", 32'(rom_rd), 32'd0);
    check("rst_rom_a", 32'(rom_a), 32'd0);
    reset = 1'b0;

    // T1: one-shot region of 3 samples
    rom_mode = 0;
    sync_stb();
    addr_q.delete();
    set_voice(0, 16'h0010, 16'd3, 1'b0);
    pulse(2'b01, 2'b00);
    check("t1_busy_on", 32'(busy), 32'h1);
    collect(5);
    check("t1_nreads", 32'(addr_q.size()), 32'd3);
    check("t1_addr0", 32'(addr_q[0]), 32'h10);
    check("t1_addr1", 32'(addr_q[1]), 32'h11);
    check("t1_addr2", 32'(addr_q[2]), 32'h12);
    check("t1_audio0", 32'(audio_q[0]), 32'h9000);
    check("t1_audio1", 32'(audio_q[1]), 32'h9100);
    check("t1_audio2", 32'(audio_q[2]), 32'h9200);
    check("t1_audio3", 32'(audio_q[3]), 32'h0000);
    check("t1_busy_mid", 32'(busy_q[1]), 32'h1);
    check("t1_busy_end", 32'(busy_q[2]), 32'h0);

    // T2: looping region, then stop
    sync_stb();
    addr_q.delete();
    set_voice(0, 16'h0010, 16'd3, 1'b1);
    pulse(2'b01, 2'b00);
    collect(5);
    check("t2_nreads", 32'(addr_q.size()), 32'd5);
    check("t2_addr3", 32'(addr_q[3]), 32'h10);
    check("t2_addr4", 32'(addr_q[4]), 32'h11);
    check("t2_audio3", 32'(audio_q[3]), 32'h9000);
    check("t2_busy_loop", 32'(busy_q[4]), 32'h1);
    pulse(2'b00, 2'b01);
    check("t2_busy_stop", 32'(busy), 32'h0);
    collect(1);
    check("t2_audio_stop", 32'(audio_q[0]), 32'h0000);

    // T3: saturation both ways, and a single unsaturated voice
    rom_mode = 1;
    sync_stb();
    set_voice(0, 16'h0000, 16'd2, 1'b1);
    set_voice(1, 16'h0000, 16'd2, 1'b1);
    pulse(2'b11, 2'b00);
    collect(2);
    check("t3_sat_hi0", 32'(audio_q[0]), 32'h7FFF);
    check("t3_sat_hi1", 32'(audio_q[1]), 32'h7FFF);
    rom_mode = 2;
    collect(2);
    check("t3_sat_lo0", 32'(audio_q[0]), 32'h8000);
    check("t3_sat_lo1", 32'(audio_q[1]), 32'h8000);
    pulse(2'b00, 2'b11);
    check("t3_busy_stop", 32'(busy), 32'h0);
    rom_mode = 1;
    set_voice(0, 16'h0000, 16'd2, 1'b1);
    pulse(2'b01, 2'b00);
    collect(1);
    check("t3_single", 32'(audio_q[0]), 32'h7F00);
    pulse(2'b00, 2'b01);

    // T4: zero-length trigger ignored; trig beats stop
    sync_stb();
    addr_q.delete();
    set_voice(1, 16'h0030, 16'd0, 1'b0);
    pulse(2'b10, 2'b00);
    check("t4_len0_busy", 32'(busy), 32'h0);
    collect(2);
    check("t4_len0_reads", 32'(addr_q.size()), 32'd0);
    set_voice(0, 16'h0010, 16'd3, 1'b1);
    pulse(2'b01, 2'b01);
    check("t4_trig_wins", 32'(busy), 32'h1);
    collect(1);
    check("t4_nreads", 32'(addr_q.size()), 32'd1);
    check("t4_addr0", 32'(addr_q[0]), 32'h10);
    pulse(2'b00, 2'b01);

    // T5: address wrap at the top of the ROM, on voice 1
    rom_mode = 0;
    sync_stb();
    addr_q.delete();
    set_voice(1, 16'hFFFE, 16'd4, 1'b0);
    pulse(2'b10, 2'b00);
    collect(5);
    check("t5_nreads", 32'(addr_q.size()), 32'd4);
    check("t5_addr0", 32'(addr_q[0]), 32'hFFFE);
    check("t5_addr1", 32'(addr_q[1]), 32'hFFFF);
    check("t5_addr2", 32'(addr_q[2]), 32'h0000);
    check("t5_addr3", 32'(addr_q[3]), 32'h0001);
    check("t5_audio0", 32'(audio_q[0]), 32'h7E00);
    check("t5_audio1", 32'(audio_q[1]), 32'h7F00);
    check("t5_audio2", 32'(audio_q[2]), 32'h8000);
    check("t5_audio3", 32'(audio_q[3]), 32'h8100);
    check("t5_audio4", 32'(audio_q[4]), 32'h0000);
    check("t5_busy_end", 32'(busy), 32'h0);

    // T6: reset during CAPT(1), then latency to the first strobe
    set_voice(0, 16'h0020, 16'd1, 1'b1);
    set_voice(1, 16'h0040, 16'd1, 1'b1);
    pulse(2'b11, 2'b00);
    collect(1);
    check("t6_pre_audio", 32'(audio_q[0]), 32'h8000);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(rom_rd && rom_a == 16'h0040) && cyc < 64);
    check("t6_issue1_seen", 32'(rom_rd), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t6_busy", 32'(busy), 32'h0);
    check("t6_audio", 32'(audio_out), 32'h0);
    check("t6_rom_rd", 32'(rom_rd), 32'h0);
    check("t6_stb", 32'(audio_stb), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end while (!audio_stb && cyc < 100);
    check("t6_latency", 32'(cyc), 32'(DIV + 1 + 2 * VOICES + 2));
    check("t6_first_out", 32'(audio_out), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
